// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and FSM state types shared by the UART macro.
package uart_pkg;
    localparam logic [2:0] REG_DATA = 3'd0, REG_STATUS = 3'd1, REG_CTRL = 3'd2, REG_PRESC = 3'd3, REG_IM = 3'd4;
    localparam int ST_TX_FULL = 0, ST_TX_EMPTY = 1, ST_RX_FULL = 2, ST_RX_EMPTY = 3;
    localparam int ST_OVR = 4, ST_FERR = 5, ST_TXDROP = 6;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word fall-through FIFO, 2^AW entries; full/empty derived from an AW+1 bit count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    // A paired push/pop is accepted even at the boundaries, leaving count unchanged.
    assign do_push = push & (!full | pop);
    assign do_pop = pop & (!empty | push);
    assign full = count[AW];
    assign empty = count == '0;
    assign rdata = mem[rptr];
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/uart_wb_fifo.sv
// uart_wb_fifo: Wishbone-slave 8N1 UART with TX/RX FIFOs, programmable prescaler,
// sticky W1C error flags and a registered maskable interrupt.
module uart_wb_fifo import uart_pkg::*; #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int FIFO_AW = 4,
    parameter logic [15:0] PRESC_RST = 16'd103
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [1:0]  io_oeb,
    output logic        uart_irq
);
    logic hit, wr, rd, w1c;
    logic [2:0] off;
    logic [1:0] ctrl;
    logic [15:0] presc, half_m1;
    logic [2:0] im;
    logic ovr, ferr, txdrop, ovr_set, ferr_set;
    logic [6:0] status;
    logic [31:0] rmux;
    logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_rdata, rx_rdata;
    logic [FIFO_AW:0] tx_count, rx_count;
    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0] tx_bit, rx_bit;
    logic [7:0] tx_sh, rx_sh;
    logic tx_tick, tx_go, rx_tick, rx_fall, rx_s1, rx_s2, rx_prev;
    logic unused;
    assign unused = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:16], tx_count, rx_count};
    assign io_oeb = 2'b01;
    // The master holds its request through the ack cycle, so side effects use the live bus inputs.
    assign off = wbs_adr_i[4:2];
    assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr = wbs_ack_o & wbs_we_i;
    assign rd = wbs_ack_o & !wbs_we_i;
    assign w1c = wr & (off == REG_STATUS);
    assign tx_push = wr & (off == REG_DATA) & wbs_sel_i[0];
    assign rx_pop = rd & (off == REG_DATA) & !rx_empty;
    always_comb begin
        status = '0;
        status[ST_TX_FULL] = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_FULL] = rx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_OVR] = ovr;
        status[ST_FERR] = ferr;
        status[ST_TXDROP] = txdrop;
    end
    assign rmux = off == REG_DATA ? {24'b0, rx_empty ? 8'h00 : rx_rdata} :
                  off == REG_STATUS ? {25'b0, status} :
                  off == REG_CTRL ? {30'b0, ctrl} :
                  off == REG_PRESC ? {16'b0, presc} :
                  off == REG_IM ? {29'b0, im} : 32'b0;
    assign wbs_dat_o = wbs_ack_o ? rmux : 32'b0;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            ctrl <= '0;
            presc <= PRESC_RST;
            im <= '0;
            ovr <= 1'b0;
            ferr <= 1'b0;
            txdrop <= 1'b0;
            uart_irq <= 1'b0;
        end else begin
            wbs_ack_o <= hit & !wbs_ack_o;
            if (wr && off == REG_CTRL) ctrl <= wbs_dat_i[1:0];
            if (wr && off == REG_PRESC) presc <= wbs_dat_i[15:0];
            if (wr && off == REG_IM) im <= wbs_dat_i[2:0];
            ovr <= ovr_set | (ovr & !(w1c & wbs_dat_i[ST_OVR]));
            ferr <= ferr_set | (ferr & !(w1c & wbs_dat_i[ST_FERR]));
            txdrop <= (tx_push & tx_full & !tx_pop) | (txdrop & !(w1c & wbs_dat_i[ST_TXDROP]));
            uart_irq <= |(im & {ovr | ferr | txdrop, tx_empty, !rx_empty});
        end
    uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_push), .pop(tx_pop), .wdata(wbs_dat_i[7:0]),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );
    uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .pop(rx_pop), .wdata(rx_sh),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );
    assign tx_tick = tx_cnt == 16'd0;
    assign tx_go = ctrl[0] & !tx_empty;
    always_comb begin
        tx_next = tx_state;
        tx_pop = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_next = tx_go ? TX_START : TX_IDLE;
                tx_pop = tx_go;
            end
            TX_START: tx_next = tx_tick ? TX_DATA : TX_START;
            TX_DATA: tx_next = (tx_tick && tx_bit == 3'd7) ? TX_STOP : TX_DATA;
            TX_STOP: begin
                tx_next = !tx_tick ? TX_STOP : tx_go ? TX_START : TX_IDLE;
                tx_pop = tx_tick & tx_go;
            end
            default: tx_next = TX_IDLE;
        endcase
    end
    assign uart_tx = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_sh[0] : 1'b1;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            tx_state <= TX_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_sh <= tx_rdata;
                tx_cnt <= presc;
                tx_bit <= 3'd0;
            end else if (tx_state != TX_IDLE) begin
                tx_cnt <= tx_tick ? presc : tx_cnt - 16'd1;
                if (tx_tick && tx_state == TX_DATA) begin
                    tx_sh <= tx_sh >> 1;
                    tx_bit <= tx_bit + 3'd1;
                end
            end
        end
    // Half-bit wait of (PRESC+1)>>1 clocks, counted down to zero.
    assign half_m1 = {1'b0, presc[15:1]} + {15'b0, presc[0]} - 16'd1;
    assign rx_tick = rx_cnt == 16'd0;
    assign rx_fall = rx_prev & !rx_s2;
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        ovr_set = 1'b0;
        ferr_set = 1'b0;
        case (rx_state)
            RX_IDLE: rx_next = (ctrl[1] && rx_fall) ? RX_START : RX_IDLE;
            RX_START: rx_next = !rx_tick ? RX_START : rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA: rx_next = (rx_tick && rx_bit == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP: begin
                rx_next = rx_tick ? RX_IDLE : RX_STOP;
                rx_push = rx_tick & rx_s2 & !rx_full;
                ovr_set = rx_tick & rx_s2 & rx_full;
                ferr_set = rx_tick & !rx_s2;
            end
            default: rx_next = RX_IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_prev <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_prev <= rx_s2;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= half_m1;
                rx_bit <= 3'd0;
            end else begin
                rx_cnt <= rx_tick ? presc : rx_cnt - 16'd1;
                if (rx_tick && rx_state == RX_DATA) begin
                    rx_sh <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                end
            end
        end
endmodule

// File: tb/tb_uart_wb_fifo.sv
// tb_uart_wb_fifo: directed stimulus with a read-data scoreboard checked on every ack.
module tb_uart_wb_fifo;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [4:0] A_DATA = 5'h00, A_STAT = 5'h04, A_CTRL = 5'h08, A_PRESC = 5'h0C, A_IM = 5'h10, A_NONE = 5'h14;
    logic clk = 1'b0, rst = 1'b1;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0] sel = '0;
    logic [31:0] adr = '0, wdat = '0, dat_o;
    logic ack, tx, irq, rx_line;
    logic rx_drv = 1'b1, loop = 1'b0, ack_prev = 1'b0;
    logic [1:0] oeb;
    logic [31:0] exp_q[$];
    int total = 0, bad = 0, cyc_n = 0;
    assign rx_line = loop ? tx : rx_drv;
    uart_wb_fifo dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
        .uart_rx(rx_line), .uart_tx(tx), .io_oeb(oeb), .uart_irq(irq)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction
    // Scoreboard monitor: every read ack pops one expected value.
    always @(negedge clk) begin
        if (ack) begin
            check("ack_single_cycle", {31'b0, ack_prev}, 32'd0);
            if (!we) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %h want none", dat_o);
                end else check("read_data", dat_o, exp_q.pop_front());
            end
        end else check("dat_o_idle", dat_o, 32'd0);
        ack_prev <= ack;
    end
    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = BASE | {27'b0, a}; wdat = d; n = 0;
        @(posedge clk); #1;
        while (!ack && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("ack_latency", n, 0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("ack_dropped", {31'b0, ack}, 32'd0);
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(1'b1, a, d);
    endtask
    task automatic rd(input logic [4:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        bus(1'b0, a, 32'd0);
    endtask
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rx_drv = f[i];
            repeat (3) @(posedge clk);
        end
        @(posedge clk); #1;
        rx_drv = 1'b1;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        logic [9:0] frame;
        int t0, n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("io_oeb", {30'b0, oeb}, 32'd1);
        rst = 1'b0;
        rd(A_STAT, 32'h0A);
        rd(A_CTRL, 32'h0);
        rd(A_PRESC, 32'd103);
        rd(A_IM, 32'h0);
        rd(A_DATA, 32'h0);
        wr(A_NONE, 32'hFFFF_FFFF);
        rd(A_NONE, 32'h0);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0104;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("foreign_no_ack", {31'b0, ack}, 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        // Basic TX of 0xA5 at 4 clocks per bit
        wr(A_PRESC, 32'd3);
        rd(A_PRESC, 32'd3);
        wr(A_CTRL, 32'd1);
        wr(A_DATA, 32'hA5);
        check("tx_latency_hi", {31'b0, tx}, 32'd1);
        @(posedge clk); #1;
        frame = 10'b1_1010_0101_0;
        for (int i = 0; i < 40; i++) begin
            check("tx_bit", {31'b0, tx}, {31'b0, frame[i/4]});
            @(posedge clk); #1;
        end
        check("tx_idle_after", {31'b0, tx}, 32'd1);
        rd(A_STAT, 32'h0A);
        // Loopback, two frames with no idle gap
        loop = 1'b1;
        wr(A_CTRL, 32'd3);
        wr(A_DATA, 32'h3C);
        check("lb_latency_hi", {31'b0, tx}, 32'd1);
        @(posedge clk); #1;
        check("lb_start", {31'b0, tx}, 32'd0);
        t0 = cyc_n;
        wr(A_DATA, 32'hC3);
        while (cyc_n < t0 + 39) begin
            @(posedge clk); #1;
        end
        check("lb_stop_bit", {31'b0, tx}, 32'd1);
        @(posedge clk); #1;
        check("lb_no_gap", {31'b0, tx}, 32'd0);
        repeat (60) @(posedge clk);
        rd(A_DATA, 32'h3C);
        rd(A_DATA, 32'hC3);
        rd(A_DATA, 32'h00);
        rd(A_STAT, 32'h0A);
        loop = 1'b0;
        wr(A_CTRL, 32'd2);
        // Overrun: 17 frames into a 16-deep RX FIFO
        for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
        repeat (4) @(posedge clk);
        rd(A_STAT, 32'h16);
        for (int i = 0; i < 16; i++) rd(A_DATA, i);
        rd(A_STAT, 32'h1A);
        wr(A_STAT, 32'h10);
        rd(A_STAT, 32'h0A);
        // Frame error with the error interrupt enabled
        wr(A_IM, 32'd4);
        send_frame(8'h55, 1'b0);
        check("irq_at_stop", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_plus1", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_plus2", {31'b0, irq}, 32'd1);
        rd(A_STAT, 32'h2A);
        wr(A_STAT, 32'h20);
        rd(A_STAT, 32'h0A);
        check("irq_cleared", {31'b0, irq}, 32'd0);
        // TX overflow: 17 writes with TX disabled, then drain through loopback
        wr(A_CTRL, 32'd0);
        for (int i = 0; i < 17; i++) wr(A_DATA, 32'h80 + i);
        rd(A_STAT, 32'h49);
        loop = 1'b1;
        wr(A_CTRL, 32'd3);
        repeat (16 * 40 + 60) @(posedge clk);
        for (int i = 0; i < 16; i++) rd(A_DATA, 32'h80 + i);
        rd(A_STAT, 32'h4A);
        wr(A_STAT, 32'h40);
        rd(A_STAT, 32'h0A);
        loop = 1'b0;
        // Reset in the middle of a TX data bit
        wr(A_CTRL, 32'd1);
        wr(A_DATA, 32'h00);
        @(posedge clk); #1;
        check("mid_start", {31'b0, tx}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("mid_data", {31'b0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", {31'b0, tx}, 32'd1);
        check("async_rst_irq", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd(A_STAT, 32'h0A);
        rd(A_CTRL, 32'h0);
        rd(A_PRESC, 32'd103);
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_tx", {31'b0, tx}, 32'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
